// File: rtl/cpuc_package.sv
// cpuc_package: shared types and constants for the CPUC memory front-end.
//   CPUC_ADDR_WIDTH - RAM word-address width (ADDR_WIDTH of the controller)
//   CPUC_DATA_WIDTH - RAM word width (the controller supports 32 only)
//   CPUC_BADDR_W    - requester byte-address width (word address + 2)
//   BYTE_OFF_W      - byte-offset width inside a word
//   NUM_MEM_REQ     - number of requesters (0 = core, 1 = debug/loader)
// Also provides CPUC_DFF_AR, the async active-low reset register macro
// (expects clk and rst_n in scope).

`ifndef CPUC_DFF_AR
`define CPUC_DFF_AR(q, d, rv) always_ff @(posedge clk or negedge rst_n) if (!rst_n) q <= (rv); else q <= (d);
`endif

package cpuc_package;
  localparam int CPUC_ADDR_WIDTH = 8;
  localparam int CPUC_DATA_WIDTH = 32;
  localparam int CPUC_BADDR_W    = CPUC_ADDR_WIDTH + 2;
  localparam int BYTE_OFF_W      = 2;
  localparam int NUM_MEM_REQ     = 2;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } t_mem_size;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } t_mem_ctrl_state;

  typedef struct packed {
    logic [CPUC_BADDR_W-1:0] addr;
    logic                    wr;
    logic [1:0]              size;
    logic                    uns;
    logic [31:0]             wdata;
  } t_mem_req;

  // Encoding 3 is not a legal size; it behaves as a word access.
  function automatic t_mem_size norm_size(input logic [1:0] s);
    return (s == 2'd3) ? MEM_WORD : t_mem_size'(s);
  endfunction
endpackage

// File: rtl/cpuc_mem_ctrl_align.sv
// cpuc_mem_align: combinational sub-word datapath.
//   rd_word   in  RAM word to extract a load from
//   old_word  in  RAM word captured for a read-modify-write
//   off       in  byte offset (already aligned to the access size)
//   size      in  access size
//   uns       in  1 = zero-extend, 0 = sign-extend
//   wdata     in  right-aligned store data
//   load_data out extracted, extended load result
//   merged    out old_word with the addressed byte/half replaced

module cpuc_mem_align
  import cpuc_package::*;
(
  input  logic [31:0]           rd_word,
  input  logic [31:0]           old_word,
  input  logic [BYTE_OFF_W-1:0] off,
  input  t_mem_size             size,
  input  logic                  uns,
  input  logic [31:0]           wdata,
  output logic [31:0]           load_data,
  output logic [31:0]           merged
);
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  always_comb begin
    sh      = {off, 3'b000};
    shifted = rd_word >> sh;
    case (size)
      MEM_BYTE: begin
        load_data = {{24{~uns & shifted[7]}}, shifted[7:0]};
        mask      = 32'h0000_00FF << sh;
      end
      MEM_HALF: begin
        load_data = {{16{~uns & shifted[15]}}, shifted[15:0]};
        mask      = 32'h0000_FFFF << sh;
      end
      default: begin
        load_data = shifted;
        mask      = 32'hFFFF_FFFF;
      end
    endcase
    merged = (old_word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/cpuc_mem_ctrl.sv
// cpuc_mem_ctrl: port-b front-end of the CPUC dual-port RAM.
// Arbitrates two byte-addressed requesters (0 = core, 1 = debug) round-robin,
// turns their requests into word accesses, performs read-modify-write for
// sub-word stores and extracts/extends sub-word loads. One transaction at a time.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake (ready is a one-hot grant in IDLE)
//   req_addr/wr/size/unsigned/wdata  per-requester request fields
//   rsp_valid            one-cycle response pulse to the granted requester
//   rsp_rdata, rsp_err   response data (0 for stores) and misalignment flag
//   address_b, wren_b, data_b, q_b   RAM port b (q_b combinational from address_b)
// Build option: CPUC_MEM_CTRL_MISALIGN_TRAP_EN makes misaligned half/word accesses
// respond with rsp_err=1 and no RAM write; otherwise the offset is forced aligned.
// Handshake: a request transfers on the clock edge where valid & ready are both
// high; the requester holds valid and all fields until then. Responses cannot be
// back-pressured.

module cpuc_mem_ctrl
  import cpuc_package::*;
(
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [NUM_MEM_REQ-1:0]                     req_valid,
  output logic [NUM_MEM_REQ-1:0]                     req_ready,
  input  logic [NUM_MEM_REQ-1:0][CPUC_BADDR_W-1:0]   req_addr,
  input  logic [NUM_MEM_REQ-1:0]                     req_wr,
  input  logic [NUM_MEM_REQ-1:0][1:0]                req_size,
  input  logic [NUM_MEM_REQ-1:0]                     req_unsigned,
  input  logic [NUM_MEM_REQ-1:0][31:0]               req_wdata,
  output logic [NUM_MEM_REQ-1:0]                     rsp_valid,
  output logic [31:0]                                rsp_rdata,
  output logic                                       rsp_err,
  output logic [CPUC_ADDR_WIDTH-1:0]                 address_b,
  output logic                                       wren_b,
  output logic [31:0]                                data_b,
  input  logic [31:0]                                q_b
);
  t_mem_ctrl_state state, state_nxt;
  logic            last_grant, last_grant_nxt;
  logic [1:0]      grant;
  logic            accept;
  t_mem_req        sel;
  t_mem_size       acc_size;
  logic [1:0]      acc_off;
  logic            acc_err;

  logic                       txn_id;
  logic [CPUC_ADDR_WIDTH-1:0] txn_addr;
  logic [BYTE_OFF_W-1:0]      txn_off;
  t_mem_size                  txn_size;
  logic                       txn_wr;
  logic                       txn_uns;
  logic                       txn_err;
  logic [31:0]                txn_wdata;
  logic [31:0]                old_word;
  logic [31:0]                rdata_q;
  logic [31:0]                load_data;
  logic [31:0]                merged;

  // Round-robin grant, only while IDLE: on a tie the requester not granted
  // last time wins. last_grant resets to 1 so requester 0 wins the first tie.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      if (req_valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else                    grant = req_valid;
    end
  end
  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    sel.addr  = req_addr[grant[1]];
    sel.wr    = req_wr[grant[1]];
    sel.size  = req_size[grant[1]];
    sel.uns   = req_unsigned[grant[1]];
    sel.wdata = req_wdata[grant[1]];
    acc_size  = norm_size(sel.size);
`ifdef CPUC_MEM_CTRL_MISALIGN_TRAP_EN
    acc_off = sel.addr[1:0];
    acc_err = ((acc_size == MEM_HALF) && sel.addr[0]) ||
              ((acc_size == MEM_WORD) && (sel.addr[1:0] != 2'b00));
`else
    acc_err = 1'b0;
    case (acc_size)
      MEM_HALF: acc_off = {sel.addr[1], 1'b0};
      MEM_WORD: acc_off = 2'b00;
      default:  acc_off = sel.addr[1:0];
    endcase
`endif
  end

  `CPUC_DFF_AR(state, state_nxt, IDLE)
  `CPUC_DFF_AR(last_grant, last_grant_nxt, 1'b1)

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: if (accept) begin
        state_nxt      = ACCESS;
        last_grant_nxt = grant[1];
      end
      ACCESS: state_nxt = (txn_wr && !txn_err && (txn_size != MEM_WORD)) ? MERGE : RESP;
      MERGE:  state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_id    <= 1'b0;
      txn_addr  <= '0;
      txn_off   <= '0;
      txn_size  <= MEM_BYTE;
      txn_wr    <= 1'b0;
      txn_uns   <= 1'b0;
      txn_err   <= 1'b0;
      txn_wdata <= '0;
      old_word  <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        txn_id    <= grant[1];
        txn_addr  <= sel.addr[CPUC_BADDR_W-1:2];
        txn_off   <= acc_off;
        txn_size  <= acc_size;
        txn_wr    <= sel.wr;
        txn_uns   <= sel.uns;
        txn_err   <= acc_err;
        txn_wdata <= sel.wdata;
      end
      if (state == ACCESS) begin
        old_word <= q_b;
        rdata_q  <= (txn_wr || txn_err) ? 32'h0 : load_data;
      end
    end
  end

  cpuc_mem_align u_align (
    .rd_word   (q_b),
    .old_word  (old_word),
    .off       (txn_off),
    .size      (txn_size),
    .uns       (txn_uns),
    .wdata     (txn_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // RAM port: idle at zero outside ACCESS/MERGE. Word stores write in ACCESS,
  // sub-word stores write the merged word in MERGE; errors never write.
  always_comb begin
    address_b = '0;
    wren_b    = 1'b0;
    data_b    = 32'h0;
    if (state == ACCESS) begin
      address_b = txn_addr;
      if (txn_wr && !txn_err && (txn_size == MEM_WORD)) begin
        wren_b = 1'b1;
        data_b = txn_wdata;
      end
    end else if (state == MERGE) begin
      address_b = txn_addr;
      wren_b    = 1'b1;
      data_b    = merged;
    end
  end

  assign rsp_valid = (state == RESP) ? (txn_id ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = (state == RESP) ? rdata_q : 32'h0;
`ifdef CPUC_MEM_CTRL_MISALIGN_TRAP_EN
  assign rsp_err = (state == RESP) && txn_err;
`else
  assign rsp_err = 1'b0;
`endif
endmodule
